// File: rtl/pwm_bank.sv
// pwm_bank: N_CH double-buffered PWM channels on one shared tick prescaler, with edge pulses.
// Optional dead-time insertion and complementary output pwm_n are enabled by `define PWM_DEADTIME_EN.
module pwm_bank #(
   parameter int N_CH  = 4,
   parameter int CW    = 8,
   parameter int PRESC = 8,
`ifdef PWM_DEADTIME_EN
   parameter int DT    = 2,
`endif
   localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            load,
   input  logic [SW-1:0]   ch_sel,
   input  logic [CW-1:0]   period,
   input  logic [CW-1:0]   on_time,
   output logic            load_ack,
   output logic            tick,
   output logic [N_CH-1:0] pwm_out,
   output logic [N_CH-1:0] set_pulse,
`ifdef PWM_DEADTIME_EN
   output logic [N_CH-1:0] pwm_n,
`endif
   output logic [N_CH-1:0] reset_pulse
);

   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);

   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic            tick_q, tick_d;
   logic            ack_q, ack_d;
   logic            adv_s, load_ok_s;

   logic [CW-1:0]   sh_per_q [N_CH];
   logic [CW-1:0]   sh_per_d [N_CH];
   logic [CW-1:0]   sh_on_q  [N_CH];
   logic [CW-1:0]   sh_on_d  [N_CH];
   logic [CW-1:0]   per_q    [N_CH];
   logic [CW-1:0]   per_d    [N_CH];
   logic [CW-1:0]   on_q     [N_CH];
   logic [CW-1:0]   on_d     [N_CH];
   logic [CW-1:0]   cnt_q    [N_CH];
   logic [CW-1:0]   cnt_d    [N_CH];

   logic [N_CH-1:0] pend_q, pend_d;
   logic [N_CH-1:0] wrap_s, wr_s, xfer_s, lvl_s;
   logic [N_CH-1:0] out_q, out_d, set_q, set_d, rst_q, rst_d;

   always_comb begin
      adv_s     = en && (pcnt_q == PMAX);
      tick_d    = adv_s;
      load_ok_s = load && (int'(ch_sel) < N_CH);
      ack_d     = load_ok_s;
      if (!en) begin
         pcnt_d = pcnt_q;
      end else if (adv_s) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + PW'(1);
      end
   end

   // A shadow only moves to the active set at a period boundary; a same-cycle load stays pending.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         wrap_s[i]   = (per_q[i] == '0) || (cnt_q[i] == per_q[i] - CW'(1));
         wr_s[i]     = load_ok_s && (ch_sel == SW'(i));
         xfer_s[i]   = adv_s && wrap_s[i] && pend_q[i];
         sh_per_d[i] = wr_s[i] ? period  : sh_per_q[i];
         sh_on_d[i]  = wr_s[i] ? on_time : sh_on_q[i];
         per_d[i]    = xfer_s[i] ? sh_per_q[i] : per_q[i];
         on_d[i]     = xfer_s[i] ? sh_on_q[i]  : on_q[i];
         pend_d[i]   = wr_s[i] | (pend_q[i] & ~xfer_s[i]);
         if (!adv_s) begin
            cnt_d[i] = cnt_q[i];
         end else if (wrap_s[i]) begin
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
         lvl_s[i] = (per_q[i] != '0) && (cnt_q[i] < on_q[i]);
      end
   end

`ifdef PWM_DEADTIME_EN
   localparam int AW = (DT > 0) ? $clog2(DT + 1) : 1;
   localparam logic [AW-1:0] DTV = AW'(DT);

   logic [N_CH-1:0] lvl_q, n_q, n_d;
   logic [AW-1:0]   age_q [N_CH];
   logic [AW-1:0]   age_d [N_CH];

   // age counts clocks since the raw level last changed; both outputs stay low until it reaches DT.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         if (lvl_s[i] != lvl_q[i]) begin
            age_d[i] = '0;
         end else if (en && (age_q[i] < DTV)) begin
            age_d[i] = age_q[i] + AW'(1);
         end else begin
            age_d[i] = age_q[i];
         end
         out_d[i] = lvl_s[i] && (age_d[i] >= DTV);
         n_d[i]   = !lvl_s[i] && (age_d[i] >= DTV);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lvl_q <= '0;
         n_q   <= '0;
         for (int i = 0; i < N_CH; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         lvl_q <= lvl_s;
         n_q   <= n_d;
         for (int i = 0; i < N_CH; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

   assign pwm_n = n_q;
`else
   always_comb begin
      out_d = lvl_s;
   end
`endif

   always_comb begin
      set_d = out_d & ~out_q;
      rst_d = out_q & ~out_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q <= '0;
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
         pend_q <= '0;
         out_q  <= '0;
         set_q  <= '0;
         rst_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            sh_per_q[i] <= '0;
            sh_on_q[i]  <= '0;
            per_q[i]    <= '0;
            on_q[i]     <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= tick_d;
         ack_q  <= ack_d;
         pend_q <= pend_d;
         out_q  <= out_d;
         set_q  <= set_d;
         rst_q  <= rst_d;
         for (int i = 0; i < N_CH; i++) begin
            sh_per_q[i] <= sh_per_d[i];
            sh_on_q[i]  <= sh_on_d[i];
            per_q[i]    <= per_d[i];
            on_q[i]     <= on_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   assign load_ack    = ack_q;
   assign tick        = tick_q;
   assign pwm_out     = out_q;
   assign set_pulse   = set_q;
   assign reset_pulse = rst_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: constant tables, directed waveform sequences and
// randomized traffic checked cycle by cycle against a tick-level reference model.
module tb_pwm_bank;
   localparam int N     = 4;
   localparam int PRESC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, en, load;
   logic [1:0] ch_sel;
   logic [7:0] period, on_time;
   logic       load_ack, tick;
   logic [N-1:0] pwm_out, set_pulse, reset_pulse;

   logic       b_reset, b_en, b_load;
   logic [1:0] b_sel;
   logic [7:0] b_per, b_on;
   logic       b_ack, b_tick;
   logic [2:0] b_pwm, b_set, b_rst;
`ifdef PWM_DEADTIME_EN
   logic [N-1:0] pwm_n;
   logic [2:0]   b_pwm_n;
`endif

   pwm_bank #(.N_CH(N), .CW(8), .PRESC(PRESC)) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .ch_sel(ch_sel),
      .period(period), .on_time(on_time), .load_ack(load_ack), .tick(tick),
      .pwm_out(pwm_out), .set_pulse(set_pulse),
`ifdef PWM_DEADTIME_EN
      .pwm_n(pwm_n),
`endif
      .reset_pulse(reset_pulse));

   pwm_bank #(.N_CH(3), .CW(8), .PRESC(1)) dut_b (
      .clk(clk), .reset(b_reset), .en(b_en), .load(b_load), .ch_sel(b_sel),
      .period(b_per), .on_time(b_on), .load_ack(b_ack), .tick(b_tick),
      .pwm_out(b_pwm), .set_pulse(b_set),
`ifdef PWM_DEADTIME_EN
      .pwm_n(b_pwm_n),
`endif
      .reset_pulse(b_rst));

   int checks, errors, cyc;

   // reference model state (whole ticks, plain integers)
   int m_pc;
   int m_per[N], m_on[N], m_cnt[N], m_sp[N], m_so[N];
   bit m_pend[N];
   logic e_tick, e_ack;
   logic [N-1:0] e_pwm, e_set, e_rst;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      logic [N-1:0] lvl;
      bit adv;
      if (reset) begin
         m_pc = 0;
         e_tick = 1'b0; e_ack = 1'b0; e_pwm = '0; e_set = '0; e_rst = '0;
         for (int i = 0; i < N; i++) begin
            m_per[i] = 0; m_on[i] = 0; m_cnt[i] = 0; m_sp[i] = 0; m_so[i] = 0; m_pend[i] = 0;
         end
      end else begin
         adv = en && (m_pc == PRESC - 1);
         for (int i = 0; i < N; i++) lvl[i] = (m_per[i] != 0) && (m_cnt[i] < m_on[i]);
         e_set  = lvl & ~e_pwm;
         e_rst  = e_pwm & ~lvl;
         e_pwm  = lvl;
         e_tick = adv;
         e_ack  = load && (int'(ch_sel) < N);
         if (en) m_pc = (m_pc + 1) % PRESC;
         for (int i = 0; i < N; i++) begin
            if (adv) begin
               if (m_per[i] == 0 || (m_cnt[i] + 1) % m_per[i] == 0) begin
                  m_cnt[i] = 0;
                  if (m_pend[i]) begin
                     m_per[i] = m_sp[i]; m_on[i] = m_so[i]; m_pend[i] = 0;
                  end
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
            if (e_ack && int'(ch_sel) == i) begin
               m_sp[i] = int'(period); m_so[i] = int'(on_time); m_pend[i] = 1;
            end
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("tick", 32'(tick), 32'(e_tick));
      chk("load_ack", 32'(load_ack), 32'(e_ack));
      chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
      chk("set_pulse", 32'(set_pulse), 32'(e_set));
      chk("reset_pulse", 32'(reset_pulse), 32'(e_rst));
   endtask

   task automatic do_load(input int ch, input int p, input int o);
      load = 1'b1; ch_sel = 2'(ch); period = 8'(p); on_time = 8'(o);
      step();
      load = 1'b0;
      chk("do_load_ack", 32'(load_ack), 32'd1);
   endtask

   task automatic wait_rise(input int ch, input int maxc);
      int n;
      n = 0;
      while (!(pwm_out[ch] && set_pulse[ch]) && n < maxc) begin
         step();
         n++;
      end
      chk("rise_seen", 32'(pwm_out[ch] && set_pulse[ch]), 32'd1);
   endtask

   task automatic run_len(input int ch, input logic lvl, input int n0, input int maxc, output int n);
      n = n0;
      step();
      while (pwm_out[ch] == lvl && n < maxc) begin
         n++;
         step();
      end
   endtask

   typedef struct packed {
      logic       ld;
      logic [1:0] sel;
      logic [7:0] per;
      logic [7:0] on;
      logic       exp_ack;
   } vec_t;

   vec_t tbl [6];

   initial begin : main
      int n, nt, ns, ns1, nr1, seen, rises;
      bit hold_ok;
      checks = 0; errors = 0; cyc = 0;
      reset = 1'b1; en = 1'b0; load = 1'b0; ch_sel = 2'd0; period = 8'd0; on_time = 8'd0;
      b_reset = 1'b1; b_en = 1'b0; b_load = 1'b0; b_sel = 2'd0; b_per = 8'd0; b_on = 8'd0;

      tbl[0] = '{1'b0, 2'd0, 8'd0,  8'd0, 1'b0};
      tbl[1] = '{1'b1, 2'd2, 8'd7,  8'd2, 1'b1};
      tbl[2] = '{1'b1, 2'd2, 8'd0,  8'd9, 1'b1};
      tbl[3] = '{1'b1, 2'd3, 8'd0,  8'd0, 1'b1};
      tbl[4] = '{1'b1, 2'd0, 8'd10, 8'd3, 1'b1};
      tbl[5] = '{1'b0, 2'd1, 8'd5,  8'd5, 1'b0};

      step(); step();
      reset = 1'b0;
      chk("reset_state", 32'({tick, load_ack, pwm_out, set_pulse, reset_pulse}), 32'd0);

      // idle run: ticks every PRESC clocks, nothing else moves
      en = 1'b1; nt = 0; ns = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         nt += int'(tick);
         ns += int'(|set_pulse) + int'(|reset_pulse) + int'(|pwm_out) + int'(load_ack);
      end
      chk("idle_ticks", nt, 32'd25);
      chk("idle_activity", ns, 32'd0);

      for (int k = 0; k < 6; k++) begin
         load = tbl[k].ld; ch_sel = tbl[k].sel; period = tbl[k].per; on_time = tbl[k].on;
         step();
         chk("tbl_ack", 32'(load_ack), 32'(tbl[k].exp_ack));
      end
      load = 1'b0;

      // ch0 period 10 on 3: 12 clk high, 28 clk low
      wait_rise(0, 100);
      run_len(0, 1'b1, 1, 200, n); chk("p1_high", n, 32'd12);
      run_len(0, 1'b0, 1, 200, n); chk("p1_low", n, 32'd28);
      chk("p2_set", 32'(set_pulse), 32'd1);

      // mid-period on=5: current period unchanged, next one 20 high
      do_load(0, 10, 5);
      run_len(0, 1'b1, 2, 200, n); chk("mid_high_old", n, 32'd12);
      run_len(0, 1'b0, 1, 200, n); chk("mid_low_old", n, 32'd28);
      run_len(0, 1'b1, 1, 200, n); chk("mid_high_new", n, 32'd20);
      run_len(0, 1'b0, 1, 200, n); chk("mid_low_new", n, 32'd20);

      // ch1: on=0 constant low; on=10 and on=200 constant high
      do_load(1, 10, 0);
      seen = 0;
      for (int k = 0; k < 100; k++) begin step(); seen += int'(pwm_out[1]); end
      chk("ch1_on0_low", seen, 32'd0);
      do_load(1, 10, 10);
      ns1 = 0; nr1 = 0;
      for (int k = 0; k < 200; k++) begin
         step(); ns1 += int'(set_pulse[1]); nr1 += int'(reset_pulse[1]);
      end
      chk("ch1_full_sets", ns1, 32'd1);
      chk("ch1_full_resets", nr1, 32'd0);
      chk("ch1_full_level", 32'(pwm_out[1]), 32'd1);
      do_load(1, 10, 200);
      ns1 = 0; nr1 = 0;
      for (int k = 0; k < 200; k++) begin
         step(); ns1 += int'(set_pulse[1]); nr1 += int'(reset_pulse[1]);
      end
      chk("ch1_over_pulses", ns1 + nr1, 32'd0);
      chk("ch1_over_level", 32'(pwm_out[1]), 32'd1);

      // drop en for 20 clk inside a 20-clk high phase
      wait_rise(0, 100);
      step(); step(); step();
      en = 1'b0; hold_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!pwm_out[0] || tick) hold_ok = 1'b0;
      end
      chk("en_hold", 32'(hold_ok), 32'd1);
      en = 1'b1;
      run_len(0, 1'b1, 24, 200, n); chk("en_stretched_high", n, 32'd40);

      // reset while high: output drops without a reset pulse
      wait_rise(0, 100);
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_mid_pwm", 32'(pwm_out), 32'd0);
      chk("rst_mid_pulse", 32'(reset_pulse), 32'd0);

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         en      = ($urandom_range(0, 7) != 0);
         load    = ($urandom_range(0, 5) == 0);
         ch_sel  = 2'($urandom_range(0, 3));
         period  = 8'($urandom_range(0, 6));
         on_time = 8'($urandom_range(0, 8));
         reset   = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0; load = 1'b0; en = 1'b1;

      // three-channel instance: out-of-range select is ignored
      step();
      b_reset = 1'b0; b_en = 1'b1;
      b_load = 1'b1; b_sel = 2'd3; b_per = 8'd2; b_on = 8'd1;
      step();
      b_load = 1'b0;
      chk("b_badsel_ack", 32'(b_ack), 32'd0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin step(); seen += int'(|b_pwm) + int'(b_ack); end
      chk("b_badsel_quiet", seen, 32'd0);
      b_load = 1'b1; b_sel = 2'd2;
      step();
      b_load = 1'b0;
      chk("b_ack", 32'(b_ack), 32'd1);
      rises = 0; seen = 0;
      for (int k = 0; k < 20; k++) begin
         step(); rises += int'(b_set[2]); seen += int'(b_pwm[0]) + int'(b_pwm[1]);
      end
      chk("b_rises", rises, 32'd10);
      chk("b_other_low", seen, 32'd0);
      chk("b_tick", 32'(b_tick), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
